data_bus_if: RTL and testbench

- Data-side bus interface directly downstream of the MEM stage.
- Takes the MEM stage's memory request (ce/we/addr/sel/data) and runs it as a single-beat cycle on an external Wishbone-style data bus that may insert wait states.
- Returns read data to the MEM stage and raises a stall request to the pipeline controller until the access completes.
- Holds completed read data while the pipeline remains stalled by another source.

---
 rtl/data_bus_if_pkg.sv | 18 +
 rtl/data_bus_if.sv | 140 ++++++++++++++
 tb/tb_data_bus_if.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/data_bus_if_pkg.sv
// Shared encodings and defaults for the MEM-stage data bus interface.
// Imported by data_bus_if and its testbench.
package data_bus_if_pkg;

   localparam int STALL_W         = 6;
   localparam int DEFAULT_TIMEOUT = 255;
   localparam int CNT_W           = 8;

   localparam logic CHIP_ENABLE   = 1'b1;
   localparam logic CHIP_DISABLE  = 1'b0;
   localparam logic WRITE_ENABLE  = 1'b1;
   localparam logic WRITE_DISABLE = 1'b0;

   localparam logic [1:0] S_IDLE       = 2'd0;
   localparam logic [1:0] S_BUSY       = 2'd1;
   localparam logic [1:0] S_WAIT_STALL = 2'd2;

endpackage

// File: rtl/data_bus_if.sv
// Runs MEM-stage loads/stores as single-beat Wishbone-style cycles with wait states,
// stalling the pipeline until ack/timeout and holding read data while stalled elsewhere.
module data_bus_if
   import data_bus_if_pkg::*;
#(
   parameter int TIMEOUT   = DEFAULT_TIMEOUT,
   parameter int STALL_IDX = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [STALL_W-1:0]  stall_i,
   input  logic                flush_i,
   input  logic                cpu_ce_i,
   input  logic                cpu_we_i,
   input  logic [31:0]         cpu_addr_i,
   input  logic [3:0]          cpu_sel_i,
   input  logic [31:0]         cpu_data_i,
   output logic [31:0]         cpu_data_o,
   output logic                stallreq_o,
   output logic                bus_err_o,
   output logic [31:0]         bus_addr_o,
   output logic [31:0]         bus_data_o,
   input  logic [31:0]         bus_data_i,
   output logic                bus_we_o,
   output logic [3:0]          bus_sel_o,
   output logic                bus_stb_o,
   output logic                bus_cyc_o,
   input  logic                bus_ack_i
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_rd_buf;
   logic             r_err;
   logic [31:0]      r_bus_addr;
   logic [31:0]      r_bus_data;
   logic             r_bus_we;
   logic [3:0]       r_bus_sel;
   logic             r_bus_stb;
   logic             r_bus_cyc;

   logic w_hold;
   logic w_busy;
   logic w_start;
   logic w_ack;
   logic w_tmo;
   logic w_is_rd;
   logic w_unused;

   // Only one bit of the stall vector matters here.
   assign w_unused = ^stall_i;
   assign w_hold   = stall_i[STALL_IDX];
   assign w_busy   = (r_state == S_BUSY);
   assign w_start  = (r_state == S_IDLE) && (cpu_ce_i == CHIP_ENABLE) && !flush_i;
   assign w_ack    = w_busy && !flush_i && bus_ack_i;
   assign w_tmo    = w_busy && !flush_i && !bus_ack_i && (r_cnt == CNT_LAST);
   assign w_is_rd  = (r_bus_we == WRITE_DISABLE);

   assign bus_addr_o = r_bus_addr;
   assign bus_data_o = r_bus_data;
   assign bus_we_o   = r_bus_we;
   assign bus_sel_o  = r_bus_sel;
   assign bus_stb_o  = r_bus_stb;
   assign bus_cyc_o  = r_bus_cyc;
   assign bus_err_o  = r_err;

   always_comb begin
      stallreq_o = 1'b0;
      cpu_data_o = 32'd0;
      if (rst) begin
         case (r_state)
            S_IDLE: stallreq_o = w_start;
            S_BUSY: begin
               stallreq_o = !flush_i && !w_ack && !w_tmo;
               if (w_ack && w_is_rd) cpu_data_o = bus_data_i;
            end
            S_WAIT_STALL: cpu_data_o = r_rd_buf;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_rd_buf   <= 32'd0;
         r_err      <= 1'b0;
         r_bus_addr <= 32'd0;
         r_bus_data <= 32'd0;
         r_bus_we   <= WRITE_DISABLE;
         r_bus_sel  <= 4'd0;
         r_bus_stb  <= 1'b0;
         r_bus_cyc  <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_bus_addr <= cpu_addr_i;
                  r_bus_data <= cpu_data_i;
                  r_bus_we   <= cpu_we_i;
                  r_bus_sel  <= cpu_sel_i;
                  r_bus_stb  <= 1'b1;
                  r_bus_cyc  <= 1'b1;
                  r_cnt      <= '0;
                  r_state    <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (flush_i || w_ack || w_tmo) begin
                  r_bus_addr <= 32'd0;
                  r_bus_data <= 32'd0;
                  r_bus_we   <= WRITE_DISABLE;
                  r_bus_sel  <= 4'd0;
                  r_bus_stb  <= 1'b0;
                  r_bus_cyc  <= 1'b0;
               end
               // Flush leaves rd_buf untouched; ack and timeout both complete the access.
               if (flush_i) begin
                  r_state <= S_IDLE;
               end else if (w_ack || w_tmo) begin
                  r_rd_buf <= (w_ack && w_is_rd) ? bus_data_i : 32'd0;
                  r_err    <= w_tmo;
                  r_state  <= w_hold ? S_WAIT_STALL : S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_WAIT_STALL: begin
               if (!w_hold || flush_i) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_bus_if.sv
// Scoreboard bench for data_bus_if: expected load data is queued at request time
// and popped in the completion cycle; timing of stall/strobe/err is checked cycle by cycle.
module tb_data_bus_if;
   import data_bus_if_pkg::*;

   localparam int TMO = 4;

   logic               clk = 1'b0;
   logic               rst;
   logic [STALL_W-1:0] stall_i;
   logic               flush_i;
   logic               cpu_ce_i;
   logic               cpu_we_i;
   logic [31:0]        cpu_addr_i;
   logic [3:0]         cpu_sel_i;
   logic [31:0]        cpu_data_i;
   logic [31:0]        cpu_data_o;
   logic               stallreq_o;
   logic               bus_err_o;
   logic [31:0]        bus_addr_o;
   logic [31:0]        bus_data_o;
   logic [31:0]        bus_data_i;
   logic               bus_we_o;
   logic [3:0]         bus_sel_o;
   logic               bus_stb_o;
   logic               bus_cyc_o;
   logic               bus_ack_i;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] sb[$];

   data_bus_if #(.TIMEOUT(TMO), .STALL_IDX(4)) dut (
      .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
      .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
      .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
      .stallreq_o(stallreq_o), .bus_err_o(bus_err_o), .bus_addr_o(bus_addr_o),
      .bus_data_o(bus_data_o), .bus_data_i(bus_data_i), .bus_we_o(bus_we_o),
      .bus_sel_o(bus_sel_o), .bus_stb_o(bus_stb_o), .bus_cyc_o(bus_cyc_o),
      .bus_ack_i(bus_ack_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] ref_v);
      n_vec++;
      if (obs !== ref_v) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, ref_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pop_chk(input string tag);
      logic [31:0] e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_underflow"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         chk(tag, cpu_data_o, e);
      end
   endtask

   task automatic request(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                          input logic [31:0] wdata);
      cpu_ce_i = CHIP_ENABLE; cpu_we_i = we; cpu_addr_i = addr;
      cpu_sel_i = sel; cpu_data_i = wdata;
      #1;
      chk("req_stallreq", {31'd0, stallreq_o}, 32'd1);
      step();
      cpu_ce_i = CHIP_DISABLE;
      chk("busy_addr", bus_addr_o, addr);
      chk("busy_data", bus_data_o, wdata);
   endtask

   // Full access: waits = wait states before ack, hold = WAIT_STALL cycles after ack.
   task automatic access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int waits, input int hold);
      sb.push_back(we ? 32'd0 : rdata);
      request(we, addr, sel, wdata);
      for (int i = 0; i < waits; i++) begin
         chk("wait_stb", {30'd0, bus_stb_o, bus_cyc_o}, 32'd3);
         chk("wait_we_sel", {27'd0, bus_we_o, bus_sel_o}, {27'd0, we, sel});
         chk("wait_stallreq", {31'd0, stallreq_o}, 32'd1);
         step();
      end
      chk("ack_stb", {30'd0, bus_stb_o, bus_cyc_o}, 32'd3);
      bus_ack_i = 1'b1; bus_data_i = rdata; stall_i[4] = (hold > 0);
      #1;
      chk("ack_stallreq", {31'd0, stallreq_o}, 32'd0);
      pop_chk("ack_data");
      step();
      bus_ack_i = 1'b0;
      #1;
      chk("post_ack_stb", {30'd0, bus_stb_o, bus_cyc_o}, 32'd0);
      chk("post_ack_err", {31'd0, bus_err_o}, 32'd0);
      for (int h = 0; h < hold; h++) begin
         bus_ack_i = 1'b1; bus_data_i = 32'hBADBAD00;
         #1;
         chk("hold_data", cpu_data_o, we ? 32'd0 : rdata);
         chk("hold_stallreq", {31'd0, stallreq_o}, 32'd0);
         chk("hold_stb", {31'd0, bus_stb_o}, 32'd0);
         if (h == hold - 1) stall_i[4] = 1'b0;
         step();
      end
      bus_ack_i = 1'b0;
      #1;
      chk("idle_data", cpu_data_o, 32'd0);
   endtask

   initial begin
      rst = 1'b0; stall_i = '0; flush_i = 1'b0; cpu_ce_i = 1'b0; cpu_we_i = 1'b0;
      cpu_addr_i = '0; cpu_sel_i = '0; cpu_data_i = '0; bus_data_i = '0; bus_ack_i = 1'b0;
      step();
      cpu_ce_i = CHIP_ENABLE;
      step();
      chk("rst_stallreq", {31'd0, stallreq_o}, 32'd0);
      chk("rst_bus", {bus_we_o, bus_sel_o, bus_stb_o, bus_cyc_o, bus_err_o}, 32'd0);
      chk("rst_addr", bus_addr_o | bus_data_o, 32'd0);
      chk("rst_cpu_data", cpu_data_o, 32'd0);
      cpu_ce_i = CHIP_DISABLE;
      rst = 1'b1;
      step();

      // Zero-wait read, then back-to-back write with 3 wait states.
      access(1'b0, 32'h0000_0010, 4'b1111, 32'd0, 32'hDEADBEEF, 0, 0);
      access(1'b1, 32'h0000_0024, 4'b0100, 32'h00AB0000, 32'h5555AAAA, 3, 0);
      // Read result held through 3 external stall cycles.
      access(1'b0, 32'h0000_0100, 4'b1111, 32'd0, 32'h12345678, 1, 3);

      // Timeout with stall held: rd_buf must be cleared, err pulses once.
      sb.push_back(32'd0);
      request(1'b0, 32'h0000_0200, 4'b0011, 32'd0);
      for (int i = 0; i < TMO - 1; i++) begin
         chk("tmo_stb", {30'd0, bus_stb_o, bus_cyc_o}, 32'd3);
         chk("tmo_stallreq", {31'd0, stallreq_o}, 32'd1);
         step();
      end
      stall_i[4] = 1'b1;
      #1;
      chk("tmo_last_stb", {31'd0, bus_stb_o}, 32'd1);
      chk("tmo_abort_stallreq", {31'd0, stallreq_o}, 32'd0);
      pop_chk("tmo_abort_data");
      step();
      chk("tmo_err_pulse", {31'd0, bus_err_o}, 32'd1);
      chk("tmo_released", {30'd0, bus_stb_o, bus_cyc_o}, 32'd0);
      chk("tmo_rdbuf", cpu_data_o, 32'd0);
      stall_i[4] = 1'b0;
      step();
      chk("tmo_err_once", {31'd0, bus_err_o}, 32'd0);

      // Flush in 2nd BUSY cycle with ack high: flush wins.
      request(1'b0, 32'h0000_0300, 4'b1111, 32'd0);
      step();
      flush_i = 1'b1; bus_ack_i = 1'b1; bus_data_i = 32'hCAFEF00D; stall_i[4] = 1'b1;
      #1;
      chk("flush_stallreq", {31'd0, stallreq_o}, 32'd0);
      chk("flush_data", cpu_data_o, 32'd0);
      step();
      chk("flush_released", {bus_we_o, bus_sel_o, bus_stb_o, bus_cyc_o, bus_err_o}, 32'd0);
      chk("flush_addr", bus_addr_o, 32'd0);
      chk("flush_idle_data", cpu_data_o, 32'd0);
      cpu_ce_i = CHIP_ENABLE;
      #1;
      chk("flush_blocks_req", {31'd0, stallreq_o}, 32'd0);
      flush_i = 1'b0; bus_ack_i = 1'b0; stall_i[4] = 1'b0; cpu_ce_i = CHIP_DISABLE;
      step();
      chk("flush_stays_idle", {31'd0, bus_stb_o}, 32'd0);

      // Reset during BUSY, then a normal access.
      request(1'b1, 32'h0000_0400, 4'b1000, 32'h7F000000);
      rst = 1'b0;
      #1;
      chk("midrst_stallreq", {31'd0, stallreq_o}, 32'd0);
      step();
      chk("midrst_bus", {bus_we_o, bus_sel_o, bus_stb_o, bus_cyc_o, bus_err_o}, 32'd0);
      chk("midrst_addr", bus_addr_o | bus_data_o, 32'd0);
      rst = 1'b1;
      step();
      access(1'b0, 32'h0000_0500, 4'b1111, 32'd0, 32'h0F1E2D3C, 2, 0);

      chk("sb_empty", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
